// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Includes the prescale decode that maps illegal ratios onto 8.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic [5:0] decode_prescale(input logic [5:0] raw);
    case (raw)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the frame controller, its edge/bit counter and the
// serial line; the controller uses the slave modport.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [4:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  cnt_enable;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, prescale, par_en, par_typ, edge_cnt, bit_cnt,
    input  cnt_enable, p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ, edge_cnt, bit_cnt,
    output cnt_enable, p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_frame_ctrl_sampler.sv
// Three-point majority sampler around the middle of each bit cell.
// The voted bit is registered on the last sample point and held until the next.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic [4:0] edge_cnt,
  output logic       voted_bit
);

  logic [5:0] mid;
  logic [5:0] edge_w;
  logic [1:0] smp;

  assign mid    = {1'b0, prescale[5:1]};
  assign edge_w = {1'b0, edge_cnt};

  always_ff @(posedge clk) begin
    if (edge_w == mid - 6'd1) smp[0] <= rx_in;
    if (edge_w == mid)        smp[1] <= rx_in;
  end

  // third sample is taken live from rx_in at mid+1 and voted in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      voted_bit <= 1'b1;
    end else if (edge_w == mid + 6'd1) begin
      voted_bit <= (smp[0] & smp[1]) | (smp[0] & rx_in) | (smp[1] & rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start validation, LSB-first deserialization,
// parity and stop checks, one registered byte per good frame.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e             state;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_flag;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  voted;
  logic [5:0]            presc;
  logic [5:0]            edge_w;
  logic                  be;
  logic                  vp;

  assign presc  = decode_prescale(bus.prescale);
  assign edge_w = {1'b0, bus.edge_cnt};
  assign be     = (edge_w == presc - 6'd1);
  assign vp     = (edge_w == {1'b0, presc[5:1]} + 6'd2);

  uart_rx_data_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (bus.rx_in),
    .prescale (presc),
    .edge_cnt (bus.edge_cnt),
    .voted_bit(voted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      shift          <= '0;
      par_flag       <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      bus.cnt_enable <= 1'b0;
      bus.p_data     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.rx_in) begin
            state          <= ST_START;
            bus.cnt_enable <= 1'b1;
            par_en_q       <= bus.par_en;
            par_typ_q      <= bus.par_typ;
            par_flag       <= 1'b0;
          end
        end
        // a start bit that votes high was a glitch: drop silently
        ST_START: begin
          if (be && bus.bit_cnt == 4'd0) begin
            if (voted) begin
              state          <= ST_IDLE;
              bus.cnt_enable <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (be) begin
            shift <= {voted, shift[DATA_WIDTH-1:1]};
            if (bus.bit_cnt == LAST_DATA_BIT) state <= par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (be) begin
            par_flag <= ((^shift) ^ par_typ_q) != voted;
            state    <= ST_STOP;
          end
        end
        // stop is judged at the vote point so the next start edge is not missed
        ST_STOP: begin
          if (vp) begin
            bus.stp_err    <= ~voted;
            bus.par_err    <= par_flag & par_en_q;
            if (voted && !(par_flag && par_en_q)) begin
              bus.p_data     <= shift;
              bus.data_valid <= 1'b1;
            end
            state          <= ST_IDLE;
            bus.cnt_enable <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          bus.cnt_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl with a behavioural edge/bit counter.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
    int         c0;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] last_good = 8'h00;
  exp_t sb[$];

  uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // upstream edge/bit counter: free-runs while enabled, clears otherwise
  always @(posedge clk) begin
    if (rst || !bus.cnt_enable) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= 4'd0;
    end else if ({1'b0, bus.edge_cnt} == bus.prescale - 6'd1) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_valid", bus.data_valid, e.dv);
        chk("par_err", bus.par_err, e.pe);
        chk("stp_err", bus.stp_err, e.se);
        chk("p_data", bus.p_data, e.pd);
        chk("latency", cyc - e.c0, e.lat);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic [5:0] ps, input bit bad_par, input bit bad_stop,
                            input int abort_bit);
    exp_t e;
    int   p;
    logic pb;
    p = int'(ps);
    bus.prescale = ps;
    bus.par_en   = pen;
    bus.par_typ  = ptyp;
    pb = (^d) ^ ptyp ^ bad_par;
    if (abort_bit < 0) begin
      e.se = bad_stop;
      e.pe = pen && bad_par;
      e.dv = !e.se && !e.pe;
      if (e.dv) last_good = d;
      e.pd  = last_good;
      e.c0  = cyc;
      e.lat = 1 + (9 + int'(pen)) * p + (p / 2 + 2) + 1;
      sb.push_back(e);
    end
    bus.rx_in = 1'b0;
    repeat (p) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      if (i == abort_bit) begin
        repeat (p / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rx_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_cnt_enable", bus.cnt_enable, 1'b0);
        chk("abort_p_data", bus.p_data, 8'h00);
        chk("abort_data_valid", bus.data_valid, 1'b0);
        chk("abort_par_err", bus.par_err, 1'b0);
        chk("abort_stp_err", bus.stp_err, 1'b0);
        last_good = 8'h00;
        return;
      end
      repeat (p) @(posedge clk);
      #1;
    end
    if (pen) begin
      bus.rx_in = pb;
      repeat (p) @(posedge clk);
      #1;
    end
    bus.rx_in = !bad_stop;
    repeat (p) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (queue %0d)", sb.size());
    $fatal(1);
  end

  initial begin
    int hi;
    bus.rx_in    = 1'b1;
    bus.prescale = PRESCALE_8;
    bus.par_en   = 1'b0;
    bus.par_typ  = PAR_EVEN;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cnt_enable", bus.cnt_enable, 1'b0);
    chk("rst_p_data", bus.p_data, 8'h00);
    chk("rst_data_valid", bus.data_valid, 1'b0);
    chk("rst_par_err", bus.par_err, 1'b0);
    chk("rst_stp_err", bus.stp_err, 1'b0);
    idle(4);

    // prescale 8, even parity, 0xA5
    send_frame(8'hA5, 1'b1, PAR_EVEN, PRESCALE_8, 1'b0, 1'b0, -1);
    idle(5);

    // prescale 16, no parity, back-to-back
    send_frame(8'h00, 1'b0, PAR_EVEN, PRESCALE_16, 1'b0, 1'b0, -1);
    send_frame(8'hFF, 1'b0, PAR_EVEN, PRESCALE_16, 1'b0, 1'b0, -1);
    send_frame(8'h3C, 1'b0, PAR_EVEN, PRESCALE_16, 1'b0, 1'b0, -1);
    idle(5);

    // prescale 32, odd parity with a wrong parity bit
    send_frame(8'h01, 1'b1, PAR_ODD, PRESCALE_32, 1'b1, 1'b0, -1);
    idle(5);

    // stop bit forced low, then a good frame
    send_frame(8'h77, 1'b0, PAR_EVEN, PRESCALE_8, 1'b0, 1'b1, -1);
    idle(32);
    chk("stop_err_back_idle", bus.cnt_enable, 1'b0);
    send_frame(8'h5A, 1'b0, PAR_EVEN, PRESCALE_8, 1'b0, 1'b0, -1);
    idle(5);

    // two-cycle start glitch at prescale 16
    bus.prescale = PRESCALE_16;
    bus.rx_in = 1'b0;
    hi = 0;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) chk("glitch_en_rise", bus.cnt_enable, 1'b1);
      if (i == 1) bus.rx_in = 1'b1;
      if (bus.cnt_enable) hi++;
    end
    chk("glitch_en_cycles", hi, 16);
    chk("glitch_en_low", bus.cnt_enable, 1'b0);
    idle(5);

    // reset in the middle of data bit 4, then a clean frame
    send_frame(8'h99, 1'b1, PAR_EVEN, PRESCALE_8, 1'b0, 1'b0, 4);
    idle(5);
    send_frame(8'hC3, 1'b1, PAR_EVEN, PRESCALE_8, 1'b0, 1'b0, -1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller for the UART receiver. It sits directly downstream of the receiver's edge/bit counter and consumes its `edge_cnt` and `bit_cnt` outputs. It drives the counter's `enable` and majority-samples the serial line. It deserializes LSB-first data, checks parity and stop bit, and emits one byte per good frame.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload bits per frame (only 8 is verified)

Ports:
- `clk` in 1: single receive oversampling clock
- `rst` in 1: synchronous, active-high reset
- `rx_in` in 1: serial line, idle high, already synchronized upstream
- `prescale` in 6: oversampling ratio; legal values 8, 16, 32; any other value is decoded as 8
- `par_en` in 1: parity bit present
- `par_typ` in 1: 0 = even, 1 = odd
- `edge_cnt` in 5: from the edge/bit counter
- `bit_cnt` in 4: from the edge/bit counter
- `cnt_enable` out 1: drives the counter `enable`; registered
- `p_data` out DATA_WIDTH: last good byte; held until the next good frame
- `data_valid` out 1: one-cycle pulse when `p_data` updates
- `par_err` out 1: one-cycle pulse at frame end on parity mismatch
- `stp_err` out 1: one-cycle pulse at frame end when the stop bit samples 0

## Operation
- Timing references, with `mid = prescale/2`:
  - Bit end (`BE`): `edge_cnt == prescale-1`.
  - Sample points: `edge_cnt == mid-1`, `mid`, `mid+1`.
  - Voted bit: registered majority of the 3 samples; valid from `edge_cnt == mid+2` (`VP`) until the next bit's first sample.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `cnt_enable` = 0.
  - If `rx_in` == 0: go to START and set `cnt_enable` = 1.
- START:
  - At `BE` with `bit_cnt == 0`: if the voted bit is 1 (glitch), go to IDLE and clear `cnt_enable`, with no error pulse.
  - Otherwise go to DATA.
- DATA:
  - At each `BE`, shift the voted bit into a shift register at the MSB and shift right, so the data is LSB first.
  - At `BE` with `bit_cnt == 8`: go to PARITY if `par_en`, else STOP.
- PARITY:
  - At `BE`, compute the expected bit: `^shift ^ par_typ`.
  - Latch a mismatch into an internal flag, then go to STOP.
- STOP is evaluated at `VP`, not `BE`, which leaves half a bit of slack for resynchronization:
  - `stp_err` = ~voted bit.
  - `par_err` = the latched flag (0 when `par_en` is 0).
  - If both are 0: `p_data` <= shift and pulse `data_valid`.
  - Go to IDLE and clear `cnt_enable`.
- Back-to-back frames: IDLE lasts at least 1 cycle, which lets the counter clear. A start edge arriving during that cycle is detected on the next cycle in IDLE.
- `par_en` and `par_typ` are sampled on leaving IDLE and held for the frame. Changes mid-frame have no effect.
- `prescale` must be stable while `cnt_enable` = 1.

## Timing
- Reset values: `cnt_enable` 0, `p_data` 0, `data_valid` 0, `par_err` 0, `stp_err` 0; state IDLE; shift register and parity flag 0.
- Reset asserted mid-frame has priority: the next cycle is IDLE with all outputs at their reset values, and no pulses are emitted.
- `cnt_enable` rises 1 cycle after the first `rx_in` == 0 sample in IDLE.
- `data_valid`, `par_err` and `stp_err` assert in the same cycle and last exactly 1 cycle.
- `data_valid` is never high together with either error.
- Frame latency from the start falling edge to `data_valid`, with P = 1 if `par_en` else 0: 1 + (9+P)·prescale + (mid+2) + 1 cycles.
- A line held low through the stop bit (break) produces `stp_err`. The controller then re-enters START as soon as IDLE sees `rx_in` == 0.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum `rx_state_e`;
  - `PAR_EVEN`/`PAR_ODD` constants;
  - `PRESCALE_8/16/32` constants;
  - a function mapping `prescale` to its legal decoded value.
- Sub-module `uart_rx_data_sampler`:
  - Inputs: `clk`, `rst`, `rx_in`, decoded `prescale`, `edge_cnt`.
  - Output: registered voted bit.
  - Function: 3-sample majority at `mid-1`, `mid`, `mid+1`.
- The top level contains the FSM, shift register, parity/stop checks and output registers.

## Test plan
- Prescale 8, `par_en`=1, even parity, byte 0xA5: `data_valid` pulses once, `p_data`=0xA5, no errors, latency matches the formula (1+80+6+1 = 88 cycles).
- Prescale 16, `par_en`=0, bytes 0x00, 0xFF, 0x3C sent back-to-back with no idle gap: three `data_valid` pulses carrying those values in that order.
- Prescale 32, odd parity, byte 0x01 sent with a wrong parity bit: `par_err` pulses, `data_valid` stays 0, `p_data` keeps its previous value.
- Stop bit forced to 0 with prescale 8: `stp_err` pulses and the FSM returns to IDLE; a following good frame with 0x5A yields `p_data`=0x5A.
- Start glitch of 2 cycles low at prescale 16: `cnt_enable` pulses high and then drops at `BE`, with no output pulses.
- `rst` asserted during the DATA bit 4 sample window: all outputs are 0 the next cycle; a following frame 0xC3 is received correctly.
